// File: rtl/serial_frame_receiver_if.sv
// Handshake bundle between a serial source/consumer and the frame receiver.
// The master side drives bits and acks; the slave side presents the byte.
interface serial_frame_receiver_if;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       data_ack;
    logic [7:0] data;
    logic       data_valid;
    logic [2:0] index;
    logic       busy;
    logic       frame_end;
    logic       overrun;

    modport master (
        output start, bit_in, bit_valid, data_ack,
        input  data, data_valid, index, busy, frame_end, overrun
    );

    modport slave (
        input  start, bit_in, bit_valid, data_ack,
        output data, data_valid, index, busy, frame_end, overrun
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// 8-bit LSB-first serial-to-parallel receiver with a 3-bit bit index
// and a valid/ack handshake on the assembled byte.
module serial_frame_receiver (
    input  logic                    i_clk,
    input  logic                    i_reset,
    serial_frame_receiver_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0] r_state;
    logic [2:0] r_index;
    logic [7:0] r_buf;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_overrun;

    logic       w_recv;
    logic       w_last;
    logic [7:0] w_start_buf;
    logic [2:0] w_start_idx;

    assign w_recv = (r_state == S_RECV);
    // start forces the effective index to 0, so it can never end a frame
    assign w_last = w_recv && !bus.start && bus.bit_valid && (r_index == 3'd7);

    assign w_start_buf = {7'd0, bus.bit_in & bus.bit_valid};
    assign w_start_idx = {2'd0, bus.bit_valid};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_index   <= 3'd0;
            r_buf     <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RECV;
                        r_buf   <= w_start_buf;
                        r_index <= w_start_idx;
                    end
                end
                S_RECV: begin
                    if (bus.start) begin
                        r_buf   <= w_start_buf;
                        r_index <= w_start_idx;
                    end else if (bus.bit_valid) begin
                        if (r_index == 3'd7) begin
                            r_data  <= {bus.bit_in, r_buf[6:0]};
                            r_valid <= 1'b1;
                            r_index <= 3'd0;
                            r_state <= S_FULL;
                        end else begin
                            r_buf[r_index] <= bus.bit_in;
                            r_index        <= r_index + 3'd1;
                        end
                    end
                end
                S_FULL: begin
                    if (bus.data_ack) begin
                        r_valid <= 1'b0;
                        if (bus.start) begin
                            r_state <= S_RECV;
                            r_buf   <= w_start_buf;
                            r_index <= w_start_idx;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (bus.bit_valid) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data       = r_data;
    assign bus.data_valid = r_valid;
    assign bus.index      = r_index;
    assign bus.busy       = w_recv;
    assign bus.frame_end  = w_last;
    assign bus.overrun    = r_overrun;
endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Synchronous 8-bit serial-to-parallel frame receiver, the receiving end of the team's 3-bit scan/sequence counting scheme. It keeps its own 3-bit bit index (0..7), shifts one serial bit per qualified cycle into position `index`, and flags end-of-loop on bit 7. It then presents the assembled byte with a valid/ack handshake. It sits between a serial source clocked on `clk` and the parallel consumer logic (display/data registers).

## Interface
Parameters: none (frame width fixed at 8 bits, index width 3 bits).

- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is high
- start  input  1  begins a new frame (index forced to 0 this cycle)
- bit_in  input  1  serial data bit, LSB first
- bit_valid  input  1  qualifies bit_in for this cycle
- data_ack  input  1  consumer accepts the presented byte
- data  output  8  last completed frame, stable while data_valid
- data_valid  output  1  completed byte waiting for ack (level)
- index  output  3  next bit position to be written (registered)
- busy  output  1  high in RECV state
- frame_end  output  1  combinational; high in the cycle the bit at index 7 is accepted (loop end)
- overrun  output  1  sticky; a bit arrived while a byte was unacknowledged

## Operation
- States: IDLE, RECV, FULL. Reset state IDLE.
- Reset values: data=8'h00, data_valid=0, index=3'd0, busy=0, frame_end=0, overrun=0, shift buffer=0.
- Accept condition: `acc = bit_valid && (state==RECV || start) && state!=FULL`.
- IDLE:
  - bit_valid without start is ignored.
  - start=1 → RECV. If bit_valid is also high, bit_in is written to buffer[0] and index becomes 1. Otherwise index stays 0.
- RECV:
  - On acc, buffer[index] <= bit_in and index <= index+1.
  - bit_valid=0 holds index and buffer; gaps of any length are allowed.
  - start=1 in RECV restarts the frame: the partial frame is discarded, the effective index is 0 and the write rule above applies, so a bit present with start becomes bit 0.
  - Accepting a bit at index 7:
    - frame_end=1 in that cycle.
    - Next edge: data <= {bit_in, buffer[6:0]}, data_valid <= 1, index wraps to 0, state → FULL.
- FULL:
  - data and data_valid hold until data_ack=1.
  - data_ack → IDLE and data_valid <= 0. If start is high in the same cycle, go to RECV instead and apply the start rule, including capture of a simultaneous bit_valid into bit 0.
  - bit_valid=1 in FULL without data_ack: the bit is dropped, overrun <= 1 and index is unchanged. start without data_ack is ignored.
  - If bit_valid and data_ack arrive in the same cycle, data_ack wins: no overrun. The bit is captured only if start is also high.
- data_ack outside FULL is ignored.
- overrun clears only on reset.
- data keeps its old value through subsequent frames until the next completion.

## Timing
- Throughput: 1 bit per cycle; 8 consecutive valid cycles complete a frame.
- Latency: the 8th bit is accepted at edge N; data and data_valid are updated after edge N, visible in cycle N+1.
- Back-to-back frames: ack in cycle N+1 with start and bit_valid gives bit 0 of the next frame with no bubble.
- frame_end is combinational from state, index and bit_valid. It is high exactly one cycle per completed frame and never in FULL or IDLE.
- index is registered:
  - increments only on acc;
  - wraps 7→0 only on frame completion;
  - is 0 in IDLE and FULL.
- Reset mid-operation (any state) takes effect at that edge and overrides start, bit_valid and data_ack. The partial frame is lost and data returns to 8'h00.

## Test plan
- Basic frame: reset, start with bits 1,0,1,0,0,1,0,1 (LSB first) on 8 consecutive cycles → frame_end pulses on the 8th cycle, data=8'hA5 and data_valid=1 next cycle, busy=0, index=0.
- Gapped input: same byte 8'h3C with bit_valid low for 3 cycles between bits 2 and 3 → data=8'h3C; index holds at 3 during the gap.
- Restart: start, 5 bits of 1, then start with bits of 8'h81 → data=8'h81; the first partial frame has no effect.
- Overrun: complete 8'hFF, withhold ack, drive bit_valid for 2 cycles → overrun=1, data stays 8'hFF. Ack → IDLE, overrun stays 1.
- Back-to-back: complete 8'h12, then in the data_valid cycle assert data_ack, start and bit_valid, followed by 7 bits → second frame 8'h34 completes 8 cycles later with no overrun.
- Reset mid-frame: after 4 bits, pulse reset → index=0, busy=0, data_valid=0, data=8'h00. A subsequent full frame of 8'h5A is received correctly.
